rv32i_decoder: RTL and testbench
================================

# rv32i_decoder

Combinational RV32I instruction decoder for the single-issue core: takes the 32-bit instruction word from fetch and produces register indices, the expanded immediate, an ALU operation code, operand-source selects and write/load/store/halt controls for execute. The only sequential element is a sticky halt flag that keeps `is_halt` asserted once an ECALL/EBREAK has been decoded.

## Interface
- No parameters.
- clk  in  1  core clock; drives only the sticky halt register.
- rst_n  in  1  asynchronous, active-low reset.
- inst  in  32  instruction word.
- rs1_src  out  5  source register 1 index (inst[19:15]); 0 when unused.
- rs2_src  out  5  source register 2 index (inst[24:20]); 0 when unused.
- rd_src  out  5  destination index (inst[11:7]); 0 when unused.
- imm  out  32  expanded immediate.
- alucode  out  6  ALU operation code.
- aluop1_type  out  2  operand 1 source.
- aluop2_type  out  2  operand 2 source.
- reg_we  out  1  register-file write enable.
- is_load  out  1  load instruction.
- is_store  out  1  store instruction.
- is_halt  out  1  halt request.

## Operation
- Operand types: NONE=0, REG=1, IMM=2, PC=3. ENABLE=1, DISABLE=0.
- alucode: LUI 0, JAL 1, JALR 2, BEQ 3, BNE 4, BLT 5, BGE 6, BLTU 7, BGEU 8, LB 9, LH 10, LW 11, LBU 12, LHU 13, SB 14, SH 15, SW 16, ADD 17, SUB 18, XOR 19, OR 20, AND 21, SLL 22, SRL 23, SRA 24, SLT 25, SLTU 26, NOP 63.
- Immediates (sign-extended from inst[31] unless stated): I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}; U = {inst[31:12],12'b0}.
- OP (0110011): rs1,rs2,rd; imm 0; types REG/REG; funct3/funct7[5] select ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
- OP-IMM (0010011): rs1,rd, rs2=0; I-imm; types REG/IMM; ADDI->ADD, SLTI->SLT, SLTIU->SLTU, XORI, ORI, ANDI. SLLI/SRLI/SRAI: imm = zero-extended inst[24:20] only (inst[30] selects SRA, not part of imm).
- LUI (0110111): rd only; U-imm; NONE/IMM; alucode LUI.
- AUIPC (0010111): rd only; U-imm; IMM/PC; alucode ADD.
- LOAD (0000011): rs1,rd; I-imm; REG/IMM; funct3 0/1/2/4/5 -> LB/LH/LW/LBU/LHU; is_load=1.
- STORE (0100011): rs1,rs2, rd=0; S-imm; REG/IMM; funct3 0/1/2 -> SB/SH/SW; is_store=1; reg_we=0.
- BRANCH (1100011): rs1,rs2, rd=0; B-imm; REG/REG; funct3 0/1/4/5/6/7 -> BEQ/BNE/BLT/BGE/BLTU/BGEU; reg_we=0.
- JAL (1101111): rd only; J-imm; NONE/PC; alucode JAL.
- JALR (1100111): rs1,rd, rs2=0; I-imm; REG/PC; alucode JALR.
- reg_we = 1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR only when rd_src != 0; else 0.
- Halt: inst == 32'h00000073 (ECALL) or 32'h00100073 (EBREAK) -> halt_now; other decode outputs as illegal.
- Illegal/unsupported opcode or funct: all indices 0, imm 0, alucode NOP, types NONE, reg_we/is_load/is_store 0.
- is_halt = halt_now OR halt_seen; halt_seen set at rising clk when halt_now, held until rst_n low.

## Timing
- All outputs except halt_seen combinational from inst; zero-cycle latency.
- halt_seen: reset value 0 (asynchronous on rst_n low); sets on first clk edge with halt_now; never clears except by reset.
- Reset mid-operation clears is_halt immediately unless halt_now is currently true.
- No handshakes; inst is sampled continuously.

## Test plan
- inst 32'h40b60633 -> rs1 12, rs2 11, rd 12, imm 0, SUB(18), REG/REG, reg_we 1.
- inst 32'hfff00513 -> rs1 0, rd 10, imm 32'hffffffff, ADD, REG/IMM; 32'h4015d793 -> rs1 11, rd 15, imm 1, SRA(24).
- inst 32'h808805b7 -> rd 11, imm 32'h80880000, LUI, NONE/IMM; 32'h817 -> rd 16, imm 0, ADD, IMM/PC.
- inst 32'hb510a3 -> rs1 10, rs2 11, rd 0, imm 1, SH(15), is_store 1, reg_we 0; 32'h251683 -> LH(10), imm 2, is_load 1, reg_we 1.
- inst 32'hfec584e3 -> BEQ, rs1 11, rs2 12, imm -24; 32'hc0006f -> JAL, rd 0, imm 12, NONE/PC, reg_we 0; 32'h8580e7 -> JALR, rs1 11, rd 1, imm 8, REG/PC, reg_we 1.
- rst_n low -> is_halt 0; inst 32'h00000073 -> is_halt 1; clk edge then inst NOP -> is_halt stays 1; rst_n low -> 0; inst 32'hffffffff -> alucode 63, all enables 0.

Source files
------------

// File: rtl/rv32i_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_decoder
// Brief    : RV32I instruction decoder with a sticky halt flag (ECALL/EBREAK).
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    output logic [4:0]  rs1_src,
    output logic [4:0]  rs2_src,
    output logic [4:0]  rd_src,
    output logic [31:0] imm,
    output logic [5:0]  alucode,
    output logic [1:0]  aluop1_type,
    output logic [1:0]  aluop2_type,
    output logic        reg_we,
    output logic        is_load,
    output logic        is_store,
    output logic        is_halt
);

    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;

    localparam logic [1:0] C_OP_NONE = 2'd0;
    localparam logic [1:0] C_OP_REG  = 2'd1;
    localparam logic [1:0] C_OP_IMM  = 2'd2;
    localparam logic [1:0] C_OP_PC   = 2'd3;

    localparam logic [5:0] C_ALU_LUI  = 6'd0;
    localparam logic [5:0] C_ALU_JAL  = 6'd1;
    localparam logic [5:0] C_ALU_JALR = 6'd2;
    localparam logic [5:0] C_ALU_BEQ  = 6'd3;
    localparam logic [5:0] C_ALU_LB   = 6'd9;
    localparam logic [5:0] C_ALU_LH   = 6'd10;
    localparam logic [5:0] C_ALU_LW   = 6'd11;
    localparam logic [5:0] C_ALU_LBU  = 6'd12;
    localparam logic [5:0] C_ALU_LHU  = 6'd13;
    localparam logic [5:0] C_ALU_SB   = 6'd14;
    localparam logic [5:0] C_ALU_ADD  = 6'd17;
    localparam logic [5:0] C_ALU_SUB  = 6'd18;
    localparam logic [5:0] C_ALU_XOR  = 6'd19;
    localparam logic [5:0] C_ALU_OR   = 6'd20;
    localparam logic [5:0] C_ALU_AND  = 6'd21;
    localparam logic [5:0] C_ALU_SLL  = 6'd22;
    localparam logic [5:0] C_ALU_SRL  = 6'd23;
    localparam logic [5:0] C_ALU_SRA  = 6'd24;
    localparam logic [5:0] C_ALU_SLT  = 6'd25;
    localparam logic [5:0] C_ALU_SLTU = 6'd26;
    localparam logic [5:0] C_ALU_NOP  = 6'd63;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_imm_sh;

    assign w_opcode = inst[6:0];
    assign w_funct3 = inst[14:12];
    assign w_funct7 = inst[31:25];
    assign w_imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign w_imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign w_imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign w_imm_u  = {inst[31:12], 12'b0};
    assign w_imm_sh = {27'b0, inst[24:20]};

    logic        w_legal, w_use_rs1, w_use_rs2, w_use_rd, w_wb, w_ld, w_st, w_halt_now;
    logic [31:0] w_imm;
    logic [5:0]  w_alu;
    logic [1:0]  w_t1, w_t2;
    logic        halt_seen_d, halt_seen_q;

    always_comb begin
        w_legal    = 1'b1;
        w_use_rs1  = 1'b0;
        w_use_rs2  = 1'b0;
        w_use_rd   = 1'b0;
        w_wb       = 1'b0;
        w_ld       = 1'b0;
        w_st       = 1'b0;
        w_imm      = 32'b0;
        w_alu      = C_ALU_NOP;
        w_t1       = C_OP_NONE;
        w_t2       = C_OP_NONE;
        w_halt_now = (inst == 32'h0000_0073) || (inst == 32'h0010_0073);
        case (w_opcode)
            C_OPC_OP: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; w_wb = 1'b1;
                w_t1 = C_OP_REG; w_t2 = C_OP_REG;
                // funct7 bit 5 is only meaningful for ADD/SUB and SRL/SRA
                w_legal = (w_funct7 == 7'h00) ||
                          ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5)));
                case (w_funct3)
                    3'd0: w_alu = w_funct7[5] ? C_ALU_SUB : C_ALU_ADD;
                    3'd1: w_alu = C_ALU_SLL;
                    3'd2: w_alu = C_ALU_SLT;
                    3'd3: w_alu = C_ALU_SLTU;
                    3'd4: w_alu = C_ALU_XOR;
                    3'd5: w_alu = w_funct7[5] ? C_ALU_SRA : C_ALU_SRL;
                    3'd6: w_alu = C_ALU_OR;
                    default: w_alu = C_ALU_AND;
                endcase
            end
            C_OPC_OPIMM: begin
                w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_wb = 1'b1;
                w_t1 = C_OP_REG; w_t2 = C_OP_IMM;
                w_imm = w_imm_i;
                case (w_funct3)
                    3'd0: w_alu = C_ALU_ADD;
                    3'd1: begin
                        w_alu = C_ALU_SLL; w_imm = w_imm_sh;
                        w_legal = (w_funct7 == 7'h00);
                    end
                    3'd2: w_alu = C_ALU_SLT;
                    3'd3: w_alu = C_ALU_SLTU;
                    3'd4: w_alu = C_ALU_XOR;
                    3'd5: begin
                        w_alu = w_funct7[5] ? C_ALU_SRA : C_ALU_SRL; w_imm = w_imm_sh;
                        w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
                    end
                    3'd6: w_alu = C_ALU_OR;
                    default: w_alu = C_ALU_AND;
                endcase
            end
            C_OPC_LUI: begin
                w_use_rd = 1'b1; w_wb = 1'b1; w_imm = w_imm_u;
                w_alu = C_ALU_LUI; w_t1 = C_OP_NONE; w_t2 = C_OP_IMM;
            end
            C_OPC_AUIPC: begin
                w_use_rd = 1'b1; w_wb = 1'b1; w_imm = w_imm_u;
                w_alu = C_ALU_ADD; w_t1 = C_OP_IMM; w_t2 = C_OP_PC;
            end
            C_OPC_LOAD: begin
                w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_wb = 1'b1; w_ld = 1'b1;
                w_imm = w_imm_i; w_t1 = C_OP_REG; w_t2 = C_OP_IMM;
                case (w_funct3)
                    3'd0: w_alu = C_ALU_LB;
                    3'd1: w_alu = C_ALU_LH;
                    3'd2: w_alu = C_ALU_LW;
                    3'd4: w_alu = C_ALU_LBU;
                    3'd5: w_alu = C_ALU_LHU;
                    default: w_legal = 1'b0;
                endcase
            end
            C_OPC_STORE: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_st = 1'b1;
                w_imm = w_imm_s; w_t1 = C_OP_REG; w_t2 = C_OP_IMM;
                w_legal = (w_funct3 <= 3'd2);
                w_alu = C_ALU_SB + {3'b0, w_funct3};
            end
            C_OPC_BRANCH: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_imm = w_imm_b; w_t1 = C_OP_REG; w_t2 = C_OP_REG;
                // BEQ,BNE at funct3 0/1 then BLT..BGEU at 4..7 map contiguously
                w_legal = (w_funct3 != 3'd2) && (w_funct3 != 3'd3);
                w_alu = w_funct3[2] ? (C_ALU_BEQ + {3'b0, w_funct3} - 6'd2)
                                    : (C_ALU_BEQ + {3'b0, w_funct3});
            end
            C_OPC_JAL: begin
                w_use_rd = 1'b1; w_wb = 1'b1; w_imm = w_imm_j;
                w_alu = C_ALU_JAL; w_t1 = C_OP_NONE; w_t2 = C_OP_PC;
            end
            C_OPC_JALR: begin
                w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_wb = 1'b1; w_imm = w_imm_i;
                w_alu = C_ALU_JALR; w_t1 = C_OP_REG; w_t2 = C_OP_PC;
                w_legal = (w_funct3 == 3'd0);
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        rs1_src     = (w_legal && w_use_rs1) ? inst[19:15] : 5'd0;
        rs2_src     = (w_legal && w_use_rs2) ? inst[24:20] : 5'd0;
        rd_src      = (w_legal && w_use_rd)  ? inst[11:7]  : 5'd0;
        imm         = w_legal ? w_imm : 32'b0;
        alucode     = w_legal ? w_alu : C_ALU_NOP;
        aluop1_type = w_legal ? w_t1 : C_OP_NONE;
        aluop2_type = w_legal ? w_t2 : C_OP_NONE;
        reg_we      = w_legal && w_wb && (inst[11:7] != 5'd0);
        is_load     = w_legal && w_ld;
        is_store    = w_legal && w_st;
        halt_seen_d = halt_seen_q | w_halt_now;
        is_halt     = w_halt_now | halt_seen_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt_seen_q <= 1'b0;
        else        halt_seen_q <= halt_seen_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_decoder
// Brief    : Directed-vector self-checking bench for rv32i_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'h0000_0013;
    logic [4:0]  rs1_src, rs2_src, rd_src;
    logic [31:0] imm;
    logic [5:0]  alucode;
    logic [1:0]  aluop1_type, aluop2_type;
    logic        reg_we, is_load, is_store, is_halt;

    int n_vec = 0;
    int n_err = 0;

    rv32i_decoder dut (
        .clk(clk), .rst_n(rst_n), .inst(inst),
        .rs1_src(rs1_src), .rs2_src(rs2_src), .rd_src(rd_src), .imm(imm),
        .alucode(alucode), .aluop1_type(aluop1_type), .aluop2_type(aluop2_type),
        .reg_we(reg_we), .is_load(is_load), .is_store(is_store), .is_halt(is_halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                           input logic [4:0] e_rd, input logic [31:0] e_imm, input logic [5:0] e_alu,
                           input logic [1:0] e_t1, input logic [1:0] e_t2, input logic e_we,
                           input logic e_ld, input logic e_st);
        chk({tag, ".rs1"},  {27'b0, rs1_src}, {27'b0, e_rs1});
        chk({tag, ".rs2"},  {27'b0, rs2_src}, {27'b0, e_rs2});
        chk({tag, ".rd"},   {27'b0, rd_src},  {27'b0, e_rd});
        chk({tag, ".imm"},  imm, e_imm);
        chk({tag, ".alu"},  {26'b0, alucode}, {26'b0, e_alu});
        chk({tag, ".t1"},   {30'b0, aluop1_type}, {30'b0, e_t1});
        chk({tag, ".t2"},   {30'b0, aluop2_type}, {30'b0, e_t2});
        chk({tag, ".we"},   {31'b0, reg_we},   {31'b0, e_we});
        chk({tag, ".ld"},   {31'b0, is_load},  {31'b0, e_ld});
        chk({tag, ".st"},   {31'b0, is_store}, {31'b0, e_st});
    endtask

    task automatic apply(input logic [31:0] v);
        @(negedge clk);
        inst = v;
        #1;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst.halt", {31'b0, is_halt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(32'h40b6_0633);
        chk_dec("sub", 5'd12, 5'd11, 5'd12, 32'd0, 6'd18, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
        chk("sub.halt", {31'b0, is_halt}, 32'd0);

        apply(32'h0073_72b3);
        chk_dec("and", 5'd6, 5'd7, 5'd5, 32'd0, 6'd21, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);

        apply(32'hfff0_0513);
        chk_dec("addi", 5'd0, 5'd0, 5'd10, 32'hffff_ffff, 6'd17, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);

        apply(32'h4015_d793);
        chk_dec("srai", 5'd11, 5'd0, 5'd15, 32'd1, 6'd24, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);

        apply(32'h8088_05b7);
        chk_dec("lui", 5'd0, 5'd0, 5'd11, 32'h8088_0000, 6'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);

        apply(32'h0000_0817);
        chk_dec("auipc", 5'd0, 5'd0, 5'd16, 32'd0, 6'd17, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0);

        apply(32'h00b5_10a3);
        chk_dec("sh", 5'd10, 5'd11, 5'd0, 32'd1, 6'd15, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1);

        apply(32'h0025_1683);
        chk_dec("lh", 5'd10, 5'd0, 5'd13, 32'd2, 6'd10, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0);

        apply(32'hfec5_84e3);
        chk_dec("beq", 5'd11, 5'd12, 5'd0, 32'hffff_ffe8, 6'd3, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);

        apply(32'h00c0_006f);
        chk_dec("jal", 5'd0, 5'd0, 5'd0, 32'd12, 6'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);

        apply(32'h0085_80e7);
        chk_dec("jalr", 5'd11, 5'd0, 5'd1, 32'd8, 6'd2, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0);

        // funct7 = 0000001 (M extension) is unsupported
        apply(32'h02b6_0633);
        chk_dec("mul_ill", 5'd0, 5'd0, 5'd0, 32'd0, 6'd63, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        apply(32'hffff_ffff);
        chk_dec("ill", 5'd0, 5'd0, 5'd0, 32'd0, 6'd63, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("ill.halt", {31'b0, is_halt}, 32'd0);

        // ECALL: combinational halt, then sticky across a clock edge
        apply(32'h0000_0073);
        chk("ecall.halt", {31'b0, is_halt}, 32'd1);
        chk_dec("ecall", 5'd0, 5'd0, 5'd0, 32'd0, 6'd63, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        apply(32'h0000_0013);
        chk("sticky.halt", {31'b0, is_halt}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst2.halt", {31'b0, is_halt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // EBREAK while in reset must not set the sticky flag
        inst = 32'h0010_0073;
        rst_n = 1'b0;
        #1;
        chk("ebreak_rst.halt", {31'b0, is_halt}, 32'd1);
        @(negedge clk);
        inst = 32'h0000_0013;
        #1;
        chk("ebreak_rst_nop.halt", {31'b0, is_halt}, 32'd0);
        rst_n = 1'b1;
        apply(32'h0010_0073);
        apply(32'h0000_0013);
        chk("ebreak.sticky", {31'b0, is_halt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
